// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream packetizer.
package axis_pkg;

    // Hold-register occupancy
    typedef enum logic {EMPTY, HOLD} pktz_state_e;

    // Why the held beat was closed (END_NONE: not closed, or not yet known)
    typedef enum logic [2:0] {
        END_NONE,
        END_COUNT,
        END_FLUSH,
        END_TIMEOUT,
        END_IDCHG
    } pktz_end_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ID_WIDTH   = 8;
    localparam int DEF_DEST_WIDTH = 8;
    localparam int DEF_USER_WIDTH = 1;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_TIMEOUT    = 256;

    // Any end reason other than END_NONE closes the frame
    function automatic logic is_close(input pktz_end_e e);
        return e != END_NONE;
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Output register slice: one entry, valid/ready, contents stable while stalled.
module axis_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_in_ready = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

    // Load on upstream handshake, drop valid once downstream takes the beat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_in_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// Frames an unframed AXI-Stream by inserting TLAST. A beat sits in the hold
// register until its TLAST is known (count end, flush, idle timeout, id/dest
// change, or the next beat arriving), then moves into the output slice.
// Optional: define AXIS_PACKETIZER_STATS_EN for stat_frames / stat_timeouts.
module axis_packetizer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = DEF_ID_WIDTH,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = DEF_DEST_WIDTH,
    parameter int USER_ENABLE = 0,
    parameter int USER_WIDTH  = DEF_USER_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  cfg_max_len,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest
`ifdef AXIS_PACKETIZER_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_timeouts
`endif
);

    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BUS_W  = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + ID_WIDTH + DEST_WIDTH + 1;

    pktz_state_e           r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_h_data;
    logic [KEEP_WIDTH-1:0] r_h_keep;
    logic [USER_WIDTH-1:0] r_h_user;
    logic [ID_WIDTH-1:0]   r_h_id;
    logic [DEST_WIDTH-1:0] r_h_dest;
    logic [LEN_WIDTH-1:0]  r_beat_cnt, r_len, w_cnt_nxt;
    logic [IDLE_W-1:0]     r_idle_cnt;

    pktz_end_e             w_end;
    logic                  w_h_valid, w_count_end, w_timeout, w_idchg;
    logic                  w_known, w_last, w_o_ready, w_move, w_accept;
    logic [BUS_W-1:0]      w_o_in, w_o_data;

    assign w_h_valid   = (r_state == HOLD);
    assign w_count_end = (r_beat_cnt == r_len - 1'b1);
    assign w_timeout   = (TIMEOUT != 0) && (r_idle_cnt == IDLE_W'(TIMEOUT));
    assign w_idchg     = ((ID_ENABLE != 0) && (s_axis_tid != r_h_id)) ||
                         ((DEST_ENABLE != 0) && (s_axis_tdest != r_h_dest));

    // Resolve the held beat's TLAST; a following beat with matching id/dest resolves it to 0
    always_comb begin
        w_end = END_NONE;
        if (w_h_valid) begin
            if (w_count_end)                   w_end = END_COUNT;
            else if (flush)                    w_end = END_FLUSH;
            else if (w_timeout)                w_end = END_TIMEOUT;
            else if (s_axis_tvalid && w_idchg) w_end = END_IDCHG;
        end
    end

    assign w_last        = is_close(w_end);
    assign w_known       = w_last || (w_h_valid && s_axis_tvalid);
    assign w_move        = w_known && w_o_ready;
    assign s_axis_tready = !rst && (!w_h_valid || w_move);
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_cnt_nxt     = w_move ? (w_last ? '0 : r_beat_cnt + 1'b1) : r_beat_cnt;

    // Hold-register state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Hold-register next state: fills on accept, empties on a move with nothing new
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept)            w_state_nxt = HOLD;
            HOLD:    if (w_move && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Hold data, beat counter, frame length latch and idle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_data   <= '0;
            r_h_keep   <= '0;
            r_h_user   <= '0;
            r_h_id     <= '0;
            r_h_dest   <= '0;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_beat_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_h_data <= s_axis_tdata;
                r_h_keep <= (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
                r_h_user <= (USER_ENABLE != 0) ? s_axis_tuser : '0;
                r_h_id   <= (ID_ENABLE != 0)   ? s_axis_tid   : '0;
                r_h_dest <= (DEST_ENABLE != 0) ? s_axis_tdest : '0;
                // first beat of a frame samples the length; later edits wait for the next frame
                if (w_cnt_nxt == '0)
                    r_len <= (cfg_max_len == '0) ? LEN_WIDTH'(1) : cfg_max_len;
            end
            if (w_accept || w_move)
                r_idle_cnt <= '0;
            else if ((TIMEOUT != 0) && w_h_valid && !s_axis_tvalid && !w_timeout)
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_o_in = {w_last, r_h_dest, r_h_id, r_h_user, r_h_keep, r_h_data};

    axis_pipe_reg #(.WIDTH(BUS_W)) u_out (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (w_known),
        .o_in_ready (w_o_ready),
        .i_data     (w_o_in),
        .o_valid    (m_axis_tvalid),
        .o_data     (w_o_data),
        .i_ready    (m_axis_tready)
    );

    assign {m_axis_tlast, m_axis_tdest, m_axis_tid, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = w_o_data;

`ifdef AXIS_PACKETIZER_STATS_EN
    logic [31:0] r_stat_frames, r_stat_timeouts;

    // Frames leaving on m_axis, and frames closed by the idle timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_frames   <= '0;
            r_stat_timeouts <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                r_stat_frames <= r_stat_frames + 1'b1;
            if (w_move && (w_end == END_TIMEOUT))
                r_stat_timeouts <= r_stat_timeouts + 1'b1;
        end
    end

    assign stat_frames   = r_stat_frames;
    assign stat_timeouts = r_stat_timeouts;
`endif

endmodule
